// File: rtl/fal6567_fb_arbiter.sv
// Frame-buffer RAM arbiter: display reads, buffered capture writes,
// and a background frame-clear engine share one single-port RAM.
module fal6567_fb_arbiter #(
    parameter int AW         = 18,
    parameter int FIFO_DEPTH = 4,
    parameter int CLR_LAST   = 137215
) (
    input  logic          clk33,
    input  logic          rst,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_adr,
    input  logic [3:0]    wr_dat,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_adr,
    output logic [3:0]    rd_dat,
    output logic          rd_vld,
    input  logic          clr_req,
    input  logic [3:0]    clr_color,
    output logic          clr_busy,
    output logic          ovf,
    input  logic          ovf_clr,
    output logic          mem_ce,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [3:0]    mem_dat_o,
    input  logic [3:0]    mem_dat_i
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] LAST_A = AW'(CLR_LAST);

    typedef enum logic {
        IDLE,
        CLEAR
    } clr_state_t;

    clr_state_t    state;
    logic [AW-1:0] clr_cnt;
    logic [3:0]    clr_col;

    logic [AW-1:0] fifo_adr [FIFO_DEPTH];
    logic [3:0]    fifo_dat [FIFO_DEPTH];
    logic [PW:0]   wp;
    logic [PW:0]   rp;

    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push;
    logic drop;
    logic clr_grant;
    logic rd_s2;

    // The extra pointer bit tells full from empty when indices match.
    assign fifo_empty = (wp == rp);
    assign fifo_full  = (wp[PW] != rp[PW]) &&
                        (wp[PW-1:0] == rp[PW-1:0]);

    // Reads always win; the FIFO gets the slot before the clear engine.
    assign pop       = !rd_req && !fifo_empty;
    assign push      = wr_req && (!fifo_full || pop);
    assign drop      = wr_req && fifo_full && !pop;
    assign clr_grant = !rd_req && fifo_empty && clr_busy;

    // Capture write FIFO storage (contents need no reset).
    always_ff @(posedge clk33) begin
        if (push) begin
            fifo_adr[wp[PW-1:0]] <= wr_adr;
            fifo_dat[wp[PW-1:0]] <= wr_dat;
        end
    end

    // FIFO pointers advance on push and pop independently.
    always_ff @(posedge clk33) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
        end
    end

    // Sticky overflow; a new drop beats a simultaneous clear.
    always_ff @(posedge clk33) begin
        if (rst)
            ovf <= 1'b0;
        else if (drop)
            ovf <= 1'b1;
        else if (ovf_clr)
            ovf <= 1'b0;
    end

    // Clear engine: walks 0..CLR_LAST using leftover slots.
    always_ff @(posedge clk33) begin
        if (rst) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
            clr_cnt  <= '0;
            clr_col  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (clr_req) begin
                        clr_col  <= clr_color;
                        clr_cnt  <= '0;
                        clr_busy <= 1'b1;
                        state    <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (clr_grant) begin
                        if (clr_cnt == LAST_A) begin
                            clr_busy <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    clr_busy <= 1'b0;
                end
            endcase
        end
    end

    // Registered RAM slot: one access per cycle by fixed priority.
    always_ff @(posedge clk33) begin
        if (rst) begin
            mem_ce    <= 1'b0;
            mem_we    <= 1'b0;
            mem_adr   <= '0;
            mem_dat_o <= '0;
        end else if (rd_req) begin
            mem_ce    <= 1'b1;
            mem_we    <= 1'b0;
            mem_adr   <= rd_adr;
            mem_dat_o <= '0;
        end else if (!fifo_empty) begin
            mem_ce    <= 1'b1;
            mem_we    <= 1'b1;
            mem_adr   <= fifo_adr[rp[PW-1:0]];
            mem_dat_o <= fifo_dat[rp[PW-1:0]];
        end else if (clr_busy) begin
            mem_ce    <= 1'b1;
            mem_we    <= 1'b1;
            mem_adr   <= clr_cnt;
            mem_dat_o <= clr_col;
        end else begin
            mem_ce    <= 1'b0;
            mem_we    <= 1'b0;
        end
    end

    // Read return: RAM data lands one edge after the access cycle,
    // then is registered here, giving a fixed 2-edge latency.
    always_ff @(posedge clk33) begin
        if (rst) begin
            rd_s2  <= 1'b0;
            rd_vld <= 1'b0;
            rd_dat <= '0;
        end else begin
            rd_s2  <= mem_ce && !mem_we;
            rd_vld <= rd_s2;
            if (rd_s2)
                rd_dat <= mem_dat_i;
        end
    end

endmodule

// File: doc/fal6567_fb_arbiter.md
Name: fal6567_fb_arbiter

Overview:
- Arbitrates the single-port 4-bit frame-buffer RAM (137216 words, 18-bit address) used by the scan converter.
- Three requesters share the RAM: the display read port (33 MHz pixel side), the capture write port (8 MHz pixel side, clken8-qualified upstream), and an internal frame-clear engine.
- Reads get fixed priority with constant latency. Writes are buffered in a small FIFO and drain in idle slots. The clear engine uses only slots left over after the FIFO.

Parameters:
- AW, 18, RAM address width.
- FIFO_DEPTH, 4, capture write FIFO entries; must be a power of 2, minimum 2.
- CLR_LAST, 137215, last address written by the clear engine.

Ports:
- clk33  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_req  in  1  capture write strobe; one write per high cycle.
- wr_adr  in  AW  capture write address.
- wr_dat  in  4  capture write colour.
- rd_req  in  1  display read strobe.
- rd_adr  in  AW  display read address.
- rd_dat  out  4  read data.
- rd_vld  out  1  rd_dat valid pulse.
- clr_req  in  1  start a frame clear (pulse).
- clr_color  in  4  fill colour; sampled when clr_req is accepted.
- clr_busy  out  1  clear in progress.
- ovf  out  1  sticky flag: a capture write was dropped.
- ovf_clr  in  1  clears ovf.
- mem_ce  out  1  RAM access enable.
- mem_we  out  1  RAM write enable; meaningful only when mem_ce=1.
- mem_adr  out  AW  RAM address.
- mem_dat_o  out  4  RAM write data.
- mem_dat_i  in  4  RAM read data; registered by the RAM one edge after the access cycle.

Behaviour:
- Reset values:
  - rd_dat=0, rd_vld=0, clr_busy=0, ovf=0, mem_ce=0, mem_we=0, mem_adr=0, mem_dat_o=0.
  - FIFO empty; clear FSM in IDLE.
- All mem_* outputs are registered. One RAM access per cycle.
- Slot selection, evaluated at every edge, highest priority first:
  - (1) rd_req: read at rd_adr.
  - (2) FIFO not empty: pop the head entry and write it.
  - (3) clr_busy: write clr_color at the clear counter.
  - (4) otherwise mem_ce=0.
- Read latency: rd_req sampled at edge E0 -> mem access cycle after E0 -> RAM data at E1 -> rd_dat/rd_vld registered at E2. Latency is fixed at 2 edges regardless of other traffic. rd_vld is a single-cycle pulse per request. Back-to-back reads are legal.
- FIFO behaviour:
  - A write is pushed when wr_req=1.
  - Push and pop in the same cycle is legal, including when the FIFO is full; occupancy is then unchanged.
  - wr_req while full with no pop that cycle: the write is dropped and ovf is set.
- ovf priority:
  - ovf_clr and a new drop in the same cycle: ovf ends at 1 (set wins).
  - Otherwise ovf_clr sets ovf to 0.
- Write ordering: FIFO writes commit to RAM in arrival order. A read of an address with a pending FIFO write returns the old RAM contents; there is no forwarding.
- Clear FSM:
  - IDLE: on clr_req, latch clr_color, set counter=0, set clr_busy=1, go to CLEAR.
  - CLEAR: on each slot granted to the clear engine, write and increment the counter. After the write at CLR_LAST, set clr_busy=0 and go to IDLE.
  - clr_req while in CLEAR is ignored; the colour is not re-latched.
- Concurrency during a clear: capture writes and reads continue. Capture writes may be overwritten later by the clear, which is the intended result.
- Reset mid-operation: the FIFO contents, the clear in progress and any read in flight are discarded. rd_vld for an aborted read never asserts.
- Counter arithmetic is AW bits wide; the counter never passes CLR_LAST.

Test Plan:
- Read latency: reset, then rd_req with rd_adr=0x00010 and RAM model word=0xA -> rd_vld high exactly 2 edges later with rd_dat=0xA. No mem_we during the read slot.
- Write drain: 3 consecutive wr_req (addresses 5, 6, 7; data 1, 2, 3) with no reads -> RAM writes at 5, 6, 7 in order on the cycles following each push. ovf stays 0.
- Contention: rd_req held high for 10 cycles while 5 writes arrive (FIFO_DEPTH=4) -> all 10 reads returned with 2-edge latency. The 5th write is dropped and ovf=1. After rd_req falls, the 4 queued writes drain in order. ovf_clr then clears ovf to 0.
- Simultaneous push/pop at full: FIFO full, rd_req low, wr_req high -> one pop and one push. Occupancy stays 4 and ovf stays 0.
- Clear: CLR_LAST=15, clr_req with clr_color=0x6 while alternate-cycle reads run -> 16 writes of 0x6 to addresses 0..15. clr_busy falls the cycle after the write to address 15. A second clr_req mid-clear has no effect.
- Reset mid-clear: assert rst after address 7 is written -> clr_busy=0 and no further clear writes. A read issued in the same cycle as rst yields no rd_vld.
